axi_wr_slave_mem: RTL and testbench

AXI write-path slave endpoint that sits directly downstream of one crossbar slave port and consumes its AW/W/B traffic.
- Accepts one write burst at a time, stores data into an internal word memory and returns a B response carrying the widened (crossbar-tagged) ID.
- A registered side-band debug read port lets benches and the read-path model inspect memory contents.

---
 rtl/axi_xbar_pkg.sv | 41 ++++
 rtl/axi_burst_addr_gen.sv | 35 +++
 rtl/axi_wr_slave_mem.sv | 165 ++++++++++++++++
 tb/tb_axi_wr_slave_mem.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar types: burst/response encodings, write FSM states and AW payload.
package axi_xbar_pkg;

    localparam int unsigned ID_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned SIZE_W     = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // Burst control captured on the AW handshake (address is tracked separately per beat)
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } aw_ctrl_t;

    function automatic logic wrap_len_legal(input logic [LEN_W-1:0] len);
        return (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
               (len == LEN_W'(7)) || (len == LEN_W'(15));
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared with the read-path model.
module axi_burst_addr_gen
    import axi_xbar_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W-1:0] size,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_len_err
);

    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] wrap_len;
    logic [ADDR_W-1:0] boundary;
    logic [ADDR_W-1:0] wrap_off;
    logic [ADDR_W-1:0] incr_addr;

    always_comb begin
        bytes        = ADDR_W'(1) << size;
        wrap_len     = (ADDR_W'(len) + ADDR_W'(1)) * bytes;
        boundary     = addr & ~(wrap_len - ADDR_W'(1));
        wrap_off     = addr - boundary;
        incr_addr    = addr + bytes;
        wrap_len_err = (burst == 2'(BURST_WRAP)) && !wrap_len_legal(len);
        next_addr    = addr;
        case (burst)
            2'(BURST_INCR): next_addr = incr_addr;
            // Return to the wrap boundary once the next beat would leave the wrap window
            2'(BURST_WRAP): next_addr = ((wrap_off + bytes) >= wrap_len) ? boundary : incr_addr;
            default:        next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// AXI write slave endpoint: one burst at a time into a word memory, B carries the captured ID.
module axi_wr_slave_mem
    import axi_xbar_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter int unsigned       ID_W      = ID_W_DEF,
    parameter int unsigned       MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         S_AWVALID,
    output logic                         S_AWREADY,
    input  logic [ID_W-1:0]              S_AWID,
    input  logic [ADDR_W-1:0]            S_AWADDR,
    input  logic [LEN_W-1:0]             S_AWLEN,
    input  logic [SIZE_W-1:0]            S_AWSIZE,
    input  logic [1:0]                   S_AWBURST,
    input  logic                         S_WVALID,
    output logic                         S_WREADY,
    input  logic [ID_W-1:0]              S_WID,
    input  logic [DATA_W-1:0]            S_WDATA,
    input  logic [DATA_W/8-1:0]          S_WSTRB,
    input  logic                         S_WLAST,
    output logic                         S_BVALID,
    input  logic                         S_BREADY,
    output logic [ID_W-1:0]              S_BID,
    output logic [1:0]                   S_BRESP,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_rdata
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned OFF_SH    = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam int unsigned MEM_BYTES = MEM_WORDS * STRB_W;

    wr_state_e         state;
    wr_state_e         state_next;
    aw_ctrl_t          aw_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beat_cnt;
    logic              dec_err;
    logic              slv_err;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [ADDR_W-1:0] next_addr_c;
    logic [ADDR_W-1:0] off_c;
    logic [IDX_W-1:0]  widx_c;
    logic              wrap_len_err_c;
    logic              size_err_c;
    logic              in_range_c;
    logic              beat_c;
    logic              last_beat_c;
    logic              beat_slv_c;
    logic              we_c;
    logic [1:0]        bresp_c;

    axi_burst_addr_gen u_addr_gen (
        .addr         (cur_addr),
        .size         (aw_q.size),
        .len          (aw_q.len),
        .burst        (aw_q.burst),
        .next_addr    (next_addr_c),
        .wrap_len_err (wrap_len_err_c)
    );

    // Per-beat decode: range, word index, protocol checks and the response this beat would close with
    always_comb begin
        off_c       = cur_addr - BASE_ADDR;
        in_range_c  = off_c < ADDR_W'(MEM_BYTES);
        widx_c      = IDX_W'(off_c >> OFF_SH);
        beat_c      = (state == DATA) && S_WVALID;
        last_beat_c = (beat_cnt == aw_q.len);
        size_err_c  = aw_q.size > SIZE_W'(OFF_SH);
        beat_slv_c  = (S_WLAST != last_beat_c) || (S_WID != id_q);
        we_c        = beat_c && !reset && in_range_c && !size_err_c && !wrap_len_err_c;
        if (dec_err || !in_range_c) begin
            bresp_c = 2'(RESP_DECERR);
        end else if (slv_err || beat_slv_c || size_err_c || wrap_len_err_c || (aw_q.burst == 2'd3)) begin
            bresp_c = 2'(RESP_SLVERR);
        end else begin
            bresp_c = 2'(RESP_OKAY);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (S_AWVALID) state_next = DATA;
            DATA:    if (beat_c && last_beat_c) state_next = RESP;
            RESP:    if (S_BREADY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst context, sticky error flags and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            S_AWREADY <= 1'b1;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b0;
            S_BID     <= '0;
            S_BRESP   <= '0;
            aw_q      <= '0;
            id_q      <= '0;
            cur_addr  <= '0;
            beat_cnt  <= '0;
            dec_err   <= 1'b0;
            slv_err   <= 1'b0;
        end else begin
            S_AWREADY <= (state_next == IDLE);
            S_WREADY  <= (state_next == DATA);
            S_BVALID  <= (state_next == RESP);
            if (state == IDLE && S_AWVALID) begin
                aw_q     <= '{len: S_AWLEN, size: S_AWSIZE, burst: S_AWBURST};
                id_q     <= S_AWID;
                cur_addr <= S_AWADDR;
                beat_cnt <= '0;
                dec_err  <= 1'b0;
                slv_err  <= 1'b0;
            end
            if (beat_c) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                cur_addr <= next_addr_c;
                dec_err  <= dec_err | !in_range_c;
                slv_err  <= slv_err | beat_slv_c;
                if (last_beat_c) begin
                    S_BID   <= id_q;
                    S_BRESP <= bresp_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (S_WSTRB[i]) begin
                    mem[widx_c][i*8 +: 8] <= S_WDATA[i*8 +: 8];
                end
            end
        end
    end

    // Read-before-write: a same-cycle W beat to dbg_addr is seen one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata <= '0;
        end else begin
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: directed scenarios plus random bursts against a byte-level memory model.
module tb_axi_wr_slave_mem;

    localparam int unsigned MW   = 1024;
    localparam int unsigned SW   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [7:0]  S_AWID;
    logic [31:0] S_AWADDR;
    logic [7:0]  S_AWLEN;
    logic [2:0]  S_AWSIZE;
    logic [1:0]  S_AWBURST;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [7:0]  S_WID;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WLAST;
    logic        S_BVALID;
    logic        S_BREADY;
    logic [7:0]  S_BID;
    logic [1:0]  S_BRESP;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    axi_wr_slave_mem #(
        .DATA_W    (32),
        .ID_W      (8),
        .MEM_WORDS (MW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_AWID    (S_AWID),
        .S_AWADDR  (S_AWADDR),
        .S_AWLEN   (S_AWLEN),
        .S_AWSIZE  (S_AWSIZE),
        .S_AWBURST (S_AWBURST),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_WID     (S_WID),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WLAST   (S_WLAST),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_BID     (S_BID),
        .S_BRESP   (S_BRESP),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       aw_ok;
        logic       w_ok;
        logic       b_on_time;
        logic       b_stable;
        logic       released;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [1:0] exp;
    } obs_t;

    int n_tests;
    int n_fail;

    logic [31:0] ref_mem [MW];
    logic [31:0] b_data  [256];
    logic [3:0]  b_strb  [256];
    logic [7:0]  b_wid   [256];
    logic        b_last  [256];

    // Reference: walk the burst beat by beat with plain arithmetic, update ref_mem, return expected BRESP
    function automatic logic [1:0] model_burst(input logic [7:0] id, input logic [31:0] addr,
                                               input logic [7:0] len, input logic [2:0] size,
                                               input logic [1:0] burst, input int n);
        logic [31:0] a, off, bytes, wlen, bnd;
        bit dec, slv, size_err, wrap_err, inr;
        a        = addr;
        bytes    = 32'd1 << size;
        dec      = 0;
        size_err = size > 3'd2;
        wrap_err = (burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        slv      = size_err || wrap_err || (burst == 2'd3);
        for (int k = 0; k < n; k++) begin
            off = a - BASE;
            inr = off < 32'(MW * SW);
            if (!inr) dec = 1;
            if (b_last[k] != (k == int'(len))) slv = 1;
            if (b_wid[k] != id) slv = 1;
            if (inr && !size_err && !wrap_err) begin
                for (int ln = 0; ln < 4; ln++) begin
                    if (b_strb[k][ln]) ref_mem[int'(off / 4)][ln*8 +: 8] = b_data[k][ln*8 +: 8];
                end
            end
            case (burst)
                2'd1: a = a + bytes;
                2'd2: begin
                    wlen = (32'(len) + 32'd1) * bytes;
                    bnd  = a - (a % wlen);
                    a    = ((a + bytes) == (bnd + wlen)) ? bnd : a + bytes;
                end
                default: a = a;
            endcase
        end
        return dec ? 2'd3 : (slv ? 2'd2 : 2'd0);
    endfunction

    task automatic fill_beats(input logic [7:0] id, input logic [7:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            b_data[k] = $urandom;
            b_strb[k] = 4'hF;
            b_wid[k]  = id;
            b_last[k] = (k == int'(len));
        end
    endtask

    task automatic dbg_read(input int idx, output logic [31:0] d);
        dbg_addr = 10'(idx);
        @(negedge clk);
        d = dbg_rdata;
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output logic ok);
        int t;
        t = 0;
        while (S_AWREADY !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok        = (S_AWREADY === 1'b1);
        S_AWVALID = 1'b1;
        S_AWID    = id;
        S_AWADDR  = addr;
        S_AWLEN   = len;
        S_AWSIZE  = size;
        S_AWBURST = burst;
        @(negedge clk);
        S_AWVALID = 1'b0;
        ok = ok && (S_WREADY === 1'b1) && (S_AWREADY === 1'b0);
    endtask

    task automatic do_beat(input int k, input int gap, output logic ok);
        repeat (gap) begin
            S_WVALID = 1'b0;
            S_WDATA  = $urandom;
            @(negedge clk);
        end
        S_WVALID = 1'b1;
        S_WDATA  = b_data[k];
        S_WSTRB  = b_strb[k];
        S_WID    = b_wid[k];
        S_WLAST  = b_last[k];
        ok = (S_WREADY === 1'b1) && (S_BVALID === 1'b0) && (S_AWREADY === 1'b0);
        @(negedge clk);
        S_WVALID = 1'b0;
        S_WLAST  = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int hold, input int gap_max, output obs_t o);
        logic ok;
        o     = '0;
        o.exp = model_burst(id, addr, len, size, burst, int'(len) + 1);
        do_aw(id, addr, len, size, burst, ok);
        o.aw_ok = ok;
        o.w_ok  = 1'b1;
        for (int k = 0; k <= int'(len); k++) begin
            do_beat(k, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, ok);
            o.w_ok = o.w_ok & ok;
        end
        o.b_on_time = S_BVALID;
        o.bid       = S_BID;
        o.bresp     = S_BRESP;
        o.b_stable  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            S_AWVALID = 1'b1;
            S_AWID    = ~id;
            S_AWADDR  = 32'h0;
            S_AWLEN   = 8'd0;
            S_BREADY  = 1'b0;
            if (!(S_BVALID === 1'b1 && S_BID === o.bid && S_BRESP === o.bresp && S_AWREADY === 1'b0))
                o.b_stable = 1'b0;
            @(negedge clk);
        end
        S_AWVALID = 1'b0;
        S_BREADY  = 1'b1;
        if (!(S_BVALID === 1'b1 && S_BID === o.bid && S_BRESP === o.bresp && S_AWREADY === 1'b0))
            o.b_stable = 1'b0;
        @(negedge clk);
        S_BREADY   = 1'b0;
        o.released = (S_BVALID === 1'b0) && (S_AWREADY === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({S_AWREADY, S_WREADY, S_BVALID, S_BID, S_BRESP, dbg_rdata} !== {1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got aw=%b w=%b b=%b bid=%h bresp=%0d dbg=%h expected 1 0 0 00 0 0",
                     S_AWREADY, S_WREADY, S_BVALID, S_BID, S_BRESP, dbg_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({S_AWREADY, S_WREADY, S_BVALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle: got aw/w/b=%b%b%b expected 100", S_AWREADY, S_WREADY, S_BVALID);
        end
    endtask

    task automatic preload_mem();
        obs_t o;
        for (int b = 0; b < 4; b++) begin
            fill_beats(8'h01, 8'd255);
            run_burst(8'h01, 32'(b * 1024), 8'd255, 3'd2, 2'd1, 0, 0, o);
        end
    endtask

    task automatic test_incr();
        obs_t o;
        logic [31:0] d;
        fill_beats(8'h21, 8'd3);
        for (int k = 0; k < 4; k++) b_data[k] = 32'(k + 1);
        run_burst(8'h21, 32'h10, 8'd3, 3'd2, 2'd1, 0, 0, o);
        n_tests++;
        if ({o.aw_ok, o.w_ok, o.b_on_time, o.b_stable, o.released} !== 5'b11111) begin
            n_fail++;
            $display("FAIL incr_handshake: got flags %b expected 11111", {o.aw_ok, o.w_ok, o.b_on_time, o.b_stable, o.released});
        end
        n_tests++;
        if (o.bid !== 8'h21 || o.bresp !== 2'd0) begin
            n_fail++;
            $display("FAIL incr_b: got bid=%h bresp=%0d expected 21 0", o.bid, o.bresp);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_read(4 + k, d);
            n_tests++;
            if (d !== 32'(k + 1)) begin
                n_fail++;
                $display("FAIL incr_word%0d: got %h expected %h", 4 + k, d, 32'(k + 1));
            end
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        logic [31:0] d;
        int widx [4];
        widx = '{14, 15, 12, 13};
        fill_beats(8'h42, 8'd3);
        for (int k = 0; k < 4; k++) b_data[k] = 32'hA + 32'(k);
        run_burst(8'h42, 32'h38, 8'd3, 3'd2, 2'd2, 1, 1, o);
        n_tests++;
        if (o.bresp !== 2'd0 || o.bid !== 8'h42 || {o.aw_ok, o.w_ok, o.b_on_time, o.released} !== 4'b1111) begin
            n_fail++;
            $display("FAIL wrap_b: got bid=%h bresp=%0d flags=%b expected 42 0 1111",
                     o.bid, o.bresp, {o.aw_ok, o.w_ok, o.b_on_time, o.released});
        end
        for (int k = 0; k < 4; k++) begin
            dbg_read(widx[k], d);
            n_tests++;
            if (d !== 32'hA + 32'(k)) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h expected %h", widx[k], d, 32'hA + 32'(k));
            end
        end
    endtask

    task automatic test_strobe();
        obs_t o;
        logic [31:0] d;
        fill_beats(8'h05, 8'd0);
        b_data[0] = 32'hFFFF_FFFF;
        run_burst(8'h05, 32'h0, 8'd0, 3'd2, 2'd1, 0, 0, o);
        fill_beats(8'h06, 8'd0);
        b_data[0] = 32'h1234_5678;
        b_strb[0] = 4'b0101;
        run_burst(8'h06, 32'h0, 8'd0, 3'd2, 2'd1, 0, 0, o);
        n_tests++;
        if (o.bresp !== 2'd0) begin
            n_fail++;
            $display("FAIL strobe_bresp: got %0d expected 0", o.bresp);
        end
        dbg_read(0, d);
        n_tests++;
        if (d !== 32'hFF34_FF78) begin
            n_fail++;
            $display("FAIL strobe_word0: got %h expected ff34ff78", d);
        end
    endtask

    task automatic test_out_of_range();
        obs_t o;
        logic [31:0] d;
        fill_beats(8'h07, 8'd0);
        run_burst(8'h07, BASE + 32'h1000, 8'd0, 3'd2, 2'd1, 0, 0, o);
        n_tests++;
        if (o.bresp !== 2'd3 || o.bid !== 8'h07) begin
            n_fail++;
            $display("FAIL oor_b: got bid=%h bresp=%0d expected 07 3", o.bid, o.bresp);
        end
        dbg_read(0, d);
        n_tests++;
        if (d !== 32'hFF34_FF78) begin
            n_fail++;
            $display("FAIL oor_word0: got %h expected ff34ff78", d);
        end
    endtask

    task automatic test_protocol_err();
        obs_t o;
        logic [31:0] d;
        fill_beats(8'h09, 8'd1);
        b_last[0] = 1'b1;
        b_last[1] = 1'b0;
        run_burst(8'h09, 32'h100, 8'd1, 3'd2, 2'd1, 0, 0, o);
        n_tests++;
        if (o.bresp !== 2'd2 || o.b_on_time !== 1'b1) begin
            n_fail++;
            $display("FAIL wlast_err_b: got bresp=%0d bvalid=%b expected 2 1", o.bresp, o.b_on_time);
        end
        for (int k = 0; k < 2; k++) begin
            dbg_read(64 + k, d);
            n_tests++;
            if (d !== b_data[k]) begin
                n_fail++;
                $display("FAIL wlast_err_word%0d: got %h expected %h", 64 + k, d, b_data[k]);
            end
        end
        fill_beats(8'h0A, 8'd1);
        run_burst(8'h0A, 32'h200, 8'd1, 3'd3, 2'd1, 0, 0, o);
        n_tests++;
        if (o.bresp !== 2'd2) begin
            n_fail++;
            $display("FAIL size_err_b: got bresp=%0d expected 2", o.bresp);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_read(128 + k, d);
            n_tests++;
            if (d !== ref_mem[128 + k]) begin
                n_fail++;
                $display("FAIL size_err_word%0d: got %h expected %h", 128 + k, d, ref_mem[128 + k]);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        fill_beats(8'h5A, 8'd2);
        run_burst(8'h5A, 32'h300, 8'd2, 3'd2, 2'd1, 5, 0, o);
        n_tests++;
        if (o.b_stable !== 1'b1 || o.bid !== 8'h5A || o.bresp !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold: got stable=%b bid=%h bresp=%0d expected 1 5a 0", o.b_stable, o.bid, o.bresp);
        end
        n_tests++;
        if (o.released !== 1'b1 || o.b_on_time !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got released=%b on_time=%b expected 1 1", o.released, o.b_on_time);
        end
    endtask

    task automatic test_reset_mid_burst();
        obs_t o;
        logic ok;
        logic [1:0] unused_resp;
        logic [31:0] d;
        logic saw_b;
        fill_beats(8'h77, 8'd0);
        run_burst(8'h77, 32'h2000, 8'd0, 3'd2, 2'd1, 0, 0, o);
        fill_beats(8'h33, 8'd3);
        unused_resp = model_burst(8'h33, 32'h400, 8'd3, 3'd2, 2'd1, 2);
        do_aw(8'h33, 32'h400, 8'd3, 3'd2, 2'd1, ok);
        do_beat(0, 0, ok);
        do_beat(1, 0, ok);
        dbg_addr = 10'd256;
        reset    = 1'b1;
        S_WVALID = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({S_AWREADY, S_WREADY, S_BVALID, S_BID, S_BRESP, dbg_rdata} !== {1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL midrst_values: got aw=%b w=%b b=%b bid=%h bresp=%0d dbg=%h expected 1 0 0 00 0 0 (prev resp %0d)",
                     S_AWREADY, S_WREADY, S_BVALID, S_BID, S_BRESP, dbg_rdata, unused_resp);
        end
        reset = 1'b0;
        saw_b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (S_BVALID !== 1'b0 || S_AWREADY !== 1'b1) saw_b = 1'b1;
        end
        n_tests++;
        if (saw_b !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_b: got stray activity=%b expected 0", saw_b);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_read(256 + k, d);
            n_tests++;
            if (d !== ref_mem[256 + k]) begin
                n_fail++;
                $display("FAIL midrst_word%0d: got %h expected %h", 256 + k, d, ref_mem[256 + k]);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [7:0] id, len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] addr, bytes;
        int kind, r;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            id   = 8'($urandom);
            len  = 8'($urandom_range(0, 15));
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (kind <= 3) begin
                burst = 2'd1;
                addr  = $urandom_range(0, 32'h10FF);
            end else if (kind <= 5) begin
                burst = 2'd0;
                addr  = $urandom_range(0, 32'h10FF);
            end else if (kind <= 8) begin
                burst = 2'd2;
                len   = 8'((2 << $urandom_range(0, 3)) - 1);
                addr  = $urandom_range(0, 32'hFFF);
            end else begin
                burst = 2'd2;
                r     = int'($urandom_range(0, 4));
                len   = (r == 0) ? 8'd0 : ((r == 1) ? 8'd2 : 8'(r + 2));
                size  = 3'($urandom_range(0, 2));
                addr  = $urandom_range(32'h400, 32'hBFF);
            end
            bytes = 32'd1 << size;
            addr  = addr & ~(bytes - 32'd1);
            fill_beats(id, len);
            for (int k = 0; k <= int'(len); k++) b_strb[k] = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, int'(len)));
                b_last[r] = ~b_last[r];
            end
            if ($urandom_range(0, 9) == 0) begin
                r = int'($urandom_range(0, int'(len)));
                b_wid[r] = b_wid[r] ^ 8'h01;
            end
            run_burst(id, addr, len, size, burst, int'($urandom_range(0, 3)), 2, o);
            n_tests++;
            if ({o.aw_ok, o.w_ok, o.b_on_time, o.b_stable, o.released} !== 5'b11111 || o.bid !== id || o.bresp !== o.exp) begin
                n_fail++;
                $display("FAIL rand%0d: got flags=%b bid=%h bresp=%0d expected 11111 %h %0d (addr=%h len=%0d size=%0d burst=%0d)",
                         it, {o.aw_ok, o.w_ok, o.b_on_time, o.b_stable, o.released}, o.bid, o.bresp,
                         id, o.exp, addr, len, size, burst);
            end
        end
    endtask

    task automatic test_mem_sweep();
        logic [31:0] d;
        for (int i = 0; i < int'(MW); i++) begin
            dbg_read(i, d);
            n_tests++;
            if (d !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL sweep_word%0d: got %h expected %h", i, d, ref_mem[i]);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        S_AWVALID = 1'b0;
        S_AWID    = '0;
        S_AWADDR  = '0;
        S_AWLEN   = '0;
        S_AWSIZE  = '0;
        S_AWBURST = '0;
        S_WVALID  = 1'b0;
        S_WID     = '0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WLAST   = 1'b0;
        S_BREADY  = 1'b0;
        dbg_addr  = '0;
        @(negedge clk);
        test_reset();
        preload_mem();
        test_incr();
        test_wrap();
        test_strobe();
        test_out_of_range();
        test_protocol_err();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        test_mem_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
